mem_bus_arbiter: RTL

Shares the single SRAM-like memory master port between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). The block accepts one transaction at a time, sequences the bus address and data handshakes, and returns the data to the requester that issued the transaction. It generates `stallreq_if` and `stallreq_mem` for the stall controller, so the pipeline holds while a requester's access is pending.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for mem_bus_arbiter: FSM state and owner encodings, bus widths.
package mem_bus_arbiter_pkg;

   localparam int BUS_ADDR_W = 32;
   localparam int BUS_DATA_W = 32;

   // Bit positions of the requesters inside the eligible/grant vectors
   localparam int REQ_IF  = 0;
   localparam int REQ_MEM = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_IF  = 1'b0,
      OWN_MEM = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IF and MEM; MEM_ARB_RR_EN turns ties
// into alternation driven by the last-served pointer.
module mem_arb_pick
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] elig_i,
`ifdef MEM_ARB_RR_EN
   input  logic       last_i,
`endif
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      if (elig_i[REQ_MEM] && elig_i[REQ_IF]) begin
`ifdef MEM_ARB_RR_EN
         if (last_i == OWN_MEM) gnt_o[REQ_IF]  = 1'b1;
         else                   gnt_o[REQ_MEM] = 1'b1;
`else
         gnt_o[REQ_MEM] = 1'b1;
`endif
      end else begin
         gnt_o = elig_i;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus master between IF and MEM, one transaction at a time.
// Optional round-robin tie breaking is enabled with MEM_ARB_RR_EN.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = BUS_ADDR_W,
   parameter int DATA_W = BUS_DATA_W
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic [ADDR_W-1:0]   inst_addr,
   input  logic                inst_flush,
   output logic                inst_grant,
   output logic                inst_rvalid,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_grant,
   output logic                data_rvalid,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata,
   output logic                stallreq_if,
   output logic                stallreq_mem
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e          state_q, state_d;
   owner_e              owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                wr_q, wr_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                discard_q, discard_d;
   logic                inst_rvalid_q, inst_rvalid_d;
   logic                data_rvalid_q, data_rvalid_d;
   logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

   logic [1:0]          elig;
   logic [1:0]          pick_gnt;
   logic [1:0]          grant;
   logic                busy;
   logic                complete;
   logic                discard_eff;

   assign busy = (state_q != ST_IDLE);
   assign elig = {data_req, inst_req & ~inst_flush};

`ifdef MEM_ARB_RR_EN
   owner_e last_q, last_d;

   always_comb begin
      last_d = last_q;
      if (|grant) last_d = grant[REQ_MEM] ? OWN_MEM : OWN_IF;
   end

   always_ff @(posedge clk) begin
      if (!resetn) last_q <= OWN_IF;
      else         last_q <= last_d;
   end
`endif

   mem_arb_pick u_pick (
      .elig_i (elig),
`ifdef MEM_ARB_RR_EN
      .last_i (last_q),
`endif
      .gnt_o  (pick_gnt)
   );

   // Grants only leave IDLE; held low during reset so every output reads 0.
   assign grant = (!busy && resetn) ? pick_gnt : 2'b00;

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      addr_d   = addr_q;
      wr_d     = wr_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      complete = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant[REQ_MEM]) begin
               state_d = ST_ADDR;
               owner_d = OWN_MEM;
               addr_d  = data_addr;
               wr_d    = data_wr;
               wstrb_d = data_wstrb;
               wdata_d = data_wdata;
            end else if (grant[REQ_IF]) begin
               state_d = ST_ADDR;
               owner_d = OWN_IF;
               addr_d  = inst_addr;
               wr_d    = 1'b0;
               wstrb_d = '0;
               wdata_d = '0;
            end
         end
         ST_ADDR: begin
            // data_ok before addr_ok belongs to nothing and is dropped
            if (bus_addr_ok) begin
               if (bus_data_ok) begin
                  state_d  = ST_IDLE;
                  complete = 1'b1;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (bus_data_ok) begin
               state_d  = ST_IDLE;
               complete = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A flush landing on the completion cycle still suppresses that fetch.
   assign discard_eff = discard_q | (inst_flush & busy & (owner_q == OWN_IF));

   always_comb begin
      discard_d     = complete ? 1'b0 : discard_eff;
      inst_rvalid_d = complete & (owner_q == OWN_IF) & ~discard_eff;
      data_rvalid_d = complete & (owner_q == OWN_MEM);
      inst_rdata_d  = inst_rvalid_d ? bus_rdata : inst_rdata_q;
      data_rdata_d  = (data_rvalid_d && !wr_q) ? bus_rdata : data_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q       <= OWN_IF;
         addr_q        <= '0;
         wr_q          <= 1'b0;
         wstrb_q       <= '0;
         wdata_q       <= '0;
         discard_q     <= 1'b0;
         inst_rvalid_q <= 1'b0;
         data_rvalid_q <= 1'b0;
         inst_rdata_q  <= '0;
         data_rdata_q  <= '0;
      end else begin
         owner_q       <= owner_d;
         addr_q        <= addr_d;
         wr_q          <= wr_d;
         wstrb_q       <= wstrb_d;
         wdata_q       <= wdata_d;
         discard_q     <= discard_d;
         inst_rvalid_q <= inst_rvalid_d;
         data_rvalid_q <= data_rvalid_d;
         inst_rdata_q  <= inst_rdata_d;
         data_rdata_q  <= data_rdata_d;
      end
   end

   assign inst_grant  = grant[REQ_IF];
   assign data_grant  = grant[REQ_MEM];
   assign inst_rvalid = inst_rvalid_q;
   assign data_rvalid = data_rvalid_q;
   assign inst_rdata  = inst_rdata_q;
   assign data_rdata  = data_rdata_q;

   assign bus_req   = (state_q == ST_ADDR);
   assign bus_wr    = wr_q;
   assign bus_wstrb = wstrb_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

   assign stallreq_mem = resetn & ((data_req & ~data_grant) |
                                   (busy & (owner_q == OWN_MEM)));
   assign stallreq_if  = resetn & ((inst_req & ~inst_grant & ~inst_flush) |
                                   (busy & (owner_q == OWN_IF) & ~discard_q));

endmodule
